// File: rtl/fadd_pkg.sv
// fadd_pkg: shared adder latency, fp32 flag bit indices and the fp32 result classifier
package fadd_pkg;
  localparam int FADD_LATENCY = 4;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int FLAG_NAN = 3;
  localparam int FLAG_INF = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_NEG = 0;
  typedef logic [3:0] fp_flags_t;
  function automatic fp_flags_t classify_fp32(input logic [31:0] w);
    fp_flags_t f;
    f[FLAG_NAN] = w[30:23] == EXP_MAX && w[22:0] != '0;
    f[FLAG_INF] = w[30:23] == EXP_MAX && w[22:0] == '0;
    f[FLAG_ZERO] = w[30:0] == '0;
    f[FLAG_NEG] = w[31];
    return f;
  endfunction
endpackage

// File: rtl/fadd_result_collector_if.sv
// fadd_result_collector_if: issue/add_result/out bundle; master = upstream+adder+consumer, slave = collector
interface fadd_result_collector_if #(parameter int TAG_W = 4);
  logic issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic issue_ready;
  logic [31:0] add_result;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic [3:0] out_flags;
  logic err_overflow;
  modport master(output issue_valid, issue_tag, add_result, out_ready,
                 input issue_ready, out_valid, out_data, out_tag, out_flags, err_overflow);
  modport slave(input issue_valid, issue_tag, add_result, out_ready,
                output issue_ready, out_valid, out_data, out_tag, out_flags, err_overflow);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; i_wr/i_wdata push, i_rd pops head o_rdata, o_count occupancy
module sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic w_rd;
  logic w_wr;
  assign w_rd = i_rd && r_count != '0;
  assign w_wr = i_wr && (r_count != CW'(DEPTH) || w_rd);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end
  always_ff @(posedge clk) begin
    r_wptr <= rst ? '0 : r_wptr + AW'(w_wr);
    r_rptr <= rst ? '0 : r_rptr + AW'(w_rd);
    r_count <= rst ? '0 : r_count + CW'(w_wr) - CW'(w_rd);
  end
endmodule

// File: rtl/fadd_result_collector.sv
// fadd_result_collector: tags PipelinedFAdd issues, captures aligned results into a FIFO with flags; ports clk, rst, bus (slave)
module fadd_result_collector import fadd_pkg::*; #(
  parameter int LATENCY = FADD_LATENCY,
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  fadd_result_collector_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W = 36 + TAG_W;
  logic [LATENCY-1:0] r_vld;
  logic [TAG_W-1:0] r_tag [LATENCY];
  logic [CW-1:0] r_credits;
  logic r_err;
  logic w_accept;
  logic w_pop;
  logic w_wr;
  logic [W-1:0] w_rdata;
  logic [CW-1:0] w_count;
  assign bus.issue_ready = r_credits != '0 && !rst;
  assign w_accept = bus.issue_valid && bus.issue_ready;
  assign bus.out_valid = w_count != '0;
  assign w_pop = bus.out_valid && bus.out_ready;
  assign w_wr = r_vld[LATENCY-1];
  assign {bus.out_data, bus.out_tag, bus.out_flags} = bus.out_valid ? w_rdata : '0;
  assign bus.err_overflow = r_err;
  always_ff @(posedge clk) begin
    r_vld[0] <= w_accept;
    r_tag[0] <= bus.issue_tag;
    for (int i = 1; i < LATENCY; i++) begin
      r_vld[i] <= r_vld[i-1] && !rst;
      r_tag[i] <= r_tag[i-1];
    end
    r_credits <= rst ? CW'(DEPTH) : r_credits - CW'(w_accept) + CW'(w_pop);
    r_err <= !rst && (r_err || (w_wr && w_count == CW'(DEPTH) && !w_pop));
  end
  sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_wr(w_wr),
    .i_wdata({bus.add_result, r_tag[LATENCY-1], classify_fp32(bus.add_result)}),
    .i_rd(w_pop),
    .o_rdata(w_rdata),
    .o_count(w_count)
  );
endmodule

// File: tb/tb_fadd_result_collector.sv
// tb_fadd_result_collector: directed checks of tagging, alignment, classification, credits and reset flush
module tb_fadd_result_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] next_res = '0;
  logic [31:0] dl [4];
  always #5 clk = ~clk;
  fadd_result_collector_if #(.TAG_W(4)) bus();
  fadd_result_collector #(.LATENCY(4), .DEPTH(8), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always @(posedge clk) begin
    dl[0] <= (bus.issue_valid && bus.issue_ready) ? next_res : 32'hBAD0BAD0;
    for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
  end
  assign bus.add_result = dl[3];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue_one(input logic [3:0] tag, input logic [31:0] res);
    bus.issue_valid = 1'b1;
    bus.issue_tag = tag;
    next_res = res;
    tick();
    bus.issue_valid = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_tag = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    n_vec++; if (bus.issue_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", bus.issue_ready); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.err_overflow !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", bus.err_overflow); end
    n_vec++; if (dut.r_credits !== 4'd8) begin n_err++; $display("FAIL rst_credits got %0d want 8", dut.r_credits); end
    rst = 1'b0;
    #1;
    n_vec++; if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready got %b want 1", bus.issue_ready); end
    n_vec++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL idle_out_data got %h want 0", bus.out_data); end
  endtask
  task automatic test_single;
    issue_one(4'd3, 32'h41BF3E67);
    for (int k = 1; k <= 4; k++) begin
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_early t+%0d got %b want 0", k, bus.out_valid); end
      tick();
    end
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
    n_vec++; if (bus.out_data !== 32'h41BF3E67) begin n_err++; $display("FAIL single_data got %h want 41bf3e67", bus.out_data); end
    n_vec++; if (bus.out_tag !== 4'd3) begin n_err++; $display("FAIL single_tag got %0d want 3", bus.out_tag); end
    n_vec++; if (bus.out_flags !== 4'b0000) begin n_err++; $display("FAIL single_flags got %b want 0000", bus.out_flags); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop got %b want 0", bus.out_valid); end
    n_vec++; if (bus.out_flags !== 4'b0000) begin n_err++; $display("FAIL single_pop_flags got %b want 0000", bus.out_flags); end
  endtask
  task automatic test_classify;
    logic [31:0] vals [6];
    logic [3:0] flg [6];
    vals = '{32'h7FC00001, 32'hFF800000, 32'h80000000, 32'h7F800000, 32'h00000001, 32'hFFC00000};
    flg = '{4'b1000, 4'b0101, 4'b0011, 4'b0100, 4'b0000, 4'b1001};
    for (int i = 0; i < 6; i++) begin
      issue_one(4'(i), vals[i]);
      repeat (4) tick();
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL cls_valid[%0d] got %b want 1", i, bus.out_valid); end
      n_vec++; if (bus.out_flags !== flg[i]) begin n_err++; $display("FAIL cls_flags[%0d] got %b want %b", i, bus.out_flags, flg[i]); end
      n_vec++; if (bus.out_data !== vals[i]) begin n_err++; $display("FAIL cls_data[%0d] got %h want %h", i, bus.out_data, vals[i]); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask
  task automatic test_backpressure;
    int acc = 0;
    bus.out_ready = 1'b0;
    repeat (12) begin
      bus.issue_valid = 1'b1;
      bus.issue_tag = acc[3:0];
      next_res = 32'h3F800000 + acc;
      if (bus.issue_ready) acc++;
      tick();
    end
    bus.issue_valid = 1'b0;
    n_vec++; if (acc != 8) begin n_err++; $display("FAIL bp_accepts got %0d want 8", acc); end
    n_vec++; if (bus.issue_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b want 0", bus.issue_ready); end
    n_vec++; if (dut.u_fifo.r_count !== 4'd8) begin n_err++; $display("FAIL bp_count got %0d want 8", dut.u_fifo.r_count); end
    n_vec++; if (bus.err_overflow !== 1'b0) begin n_err++; $display("FAIL bp_err got %b want 0", bus.err_overflow); end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j == 0) begin
        n_vec++; if (bus.issue_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_at_pop got %b want 0", bus.issue_ready); end
      end
      n_vec++; if (bus.out_tag !== 4'(j)) begin n_err++; $display("FAIL bp_tag[%0d] got %0d want %0d", j, bus.out_tag, j); end
      n_vec++; if (bus.out_data !== 32'h3F800000 + 32'(j)) begin n_err++; $display("FAIL bp_data[%0d] got %h want %h", j, bus.out_data, 32'h3F800000 + 32'(j)); end
      tick();
      if (j == 0) begin
        n_vec++; if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_return got %b want 1", bus.issue_ready); end
      end
    end
    bus.out_ready = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b want 0", bus.out_valid); end
    n_vec++; if (dut.r_credits !== 4'd8) begin n_err++; $display("FAIL bp_credits got %0d want 8", dut.r_credits); end
  endtask
  task automatic test_bubbles;
    logic [3:0] exp_cnt [9];
    logic [31:0] exp_dat [3];
    exp_cnt = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3};
    exp_dat = '{32'h3F800000, 32'hC0000000, 32'h00000000};
    for (int c = 0; c < 9; c++) begin
      bus.issue_valid = (c == 0 || c == 2 || c == 3);
      bus.issue_tag = c == 0 ? 4'd10 : c == 2 ? 4'd11 : 4'd12;
      next_res = c == 0 ? exp_dat[0] : c == 2 ? exp_dat[1] : exp_dat[2];
      n_vec++; if (dut.u_fifo.r_count !== exp_cnt[c]) begin n_err++; $display("FAIL bub_count[c%0d] got %0d want %0d", c, dut.u_fifo.r_count, exp_cnt[c]); end
      tick();
    end
    bus.issue_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      n_vec++; if (bus.out_tag !== 4'(10 + j)) begin n_err++; $display("FAIL bub_tag[%0d] got %0d want %0d", j, bus.out_tag, 10 + j); end
      n_vec++; if (bus.out_data !== exp_dat[j]) begin n_err++; $display("FAIL bub_data[%0d] got %h want %h", j, bus.out_data, exp_dat[j]); end
      tick();
    end
    bus.out_ready = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bub_drained got %b want 0", bus.out_valid); end
  endtask
  task automatic test_back_to_back;
    int i = 0;
    int rx = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && rx < 100; cyc++) begin
      bus.issue_valid = i < 100;
      if (i < 100) begin
        bus.issue_tag = i[3:0];
        next_res = 32'h40000000 + i;
        n_vec++; if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want 1", i, bus.issue_ready); end
        i++;
      end
      if (bus.out_valid) begin
        n_vec++; if (bus.out_tag !== rx[3:0]) begin n_err++; $display("FAIL b2b_tag[%0d] got %0d want %0d", rx, bus.out_tag, rx[3:0]); end
        n_vec++; if (bus.out_data !== 32'h40000000 + rx) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", rx, bus.out_data, 32'h40000000 + rx); end
        rx++;
      end
      tick();
    end
    bus.issue_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_vec++; if (rx != 100) begin n_err++; $display("FAIL b2b_received got %0d want 100", rx); end
    n_vec++; if (dut.r_credits !== 4'd8) begin n_err++; $display("FAIL b2b_credits got %0d want 8", dut.r_credits); end
    n_vec++; if (bus.err_overflow !== 1'b0) begin n_err++; $display("FAIL b2b_err got %b want 0", bus.err_overflow); end
  endtask
  task automatic test_reset_flight;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) issue_one(4'(k), 32'h3F000000 + 32'(k));
    tick();
    n_vec++; if (dut.u_fifo.r_count !== 4'd2) begin n_err++; $display("FAIL rf_pre_count got %0d want 2", dut.u_fifo.r_count); end
    rst = 1'b1;
    #1;
    n_vec++; if (bus.issue_ready !== 1'b0) begin n_err++; $display("FAIL rf_ready_in_rst got %b want 0", bus.issue_ready); end
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rf_out_valid got %b want 0", bus.out_valid); end
    n_vec++; if (dut.r_credits !== 4'd8) begin n_err++; $display("FAIL rf_credits got %0d want 8", dut.r_credits); end
    n_vec++; if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL rf_ready got %b want 1", bus.issue_ready); end
    for (int c = 0; c < 6; c++) begin
      n_vec++; if (dut.u_fifo.r_count !== 4'd0) begin n_err++; $display("FAIL rf_no_write[c%0d] got %0d want 0", c, dut.u_fifo.r_count); end
      tick();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.issue_valid = 1'b0;
    bus.issue_tag = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_classify();
    test_backpressure();
    test_bubbles();
    test_back_to_back();
    test_reset_flight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fadd_result_collector.md
Name: fadd_result_collector

Overview:
- Downstream companion to the 4-stage PipelinedFAdd, which has no valid or stall signals.
- Tracks which adder cycles carry real operations and tags them through a valid/tag shift register aligned to the adder latency.
- Captures each matching adder result into a small FIFO, classifies it (NaN/Inf/zero/sign), and presents it on a valid/ready output.
- Gates operand issue with a credit counter, so a result can never be lost while the adder cannot stall.

Parameters:
- LATENCY, 4: cycles from operand sample by the adder to the matching result on add_result; must be ≥1.
- DEPTH, 8: FIFO entries; power of two, ≥2.
- TAG_W, 4: width of the user tag carried alongside each operation.

Ports:
- clk  input  1  rising-edge clock, shared with PipelinedFAdd.
- rst  input  1  synchronous, active-high reset.
- issue_valid  input  1  upstream presents A/B/operation to the adder this cycle.
- issue_tag  input  TAG_W  tag of the issued operation.
- issue_ready  output  1  credit available; issue accepted when issue_valid && issue_ready.
- add_result  input  32  PipelinedFAdd result output.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  32  result word.
- out_tag  output  TAG_W  tag of the result.
- out_flags  output  4  {is_nan, is_inf, is_zero, is_neg}.
- err_overflow  output  1  sticky; FIFO write attempted while full. Must never assert.

Behaviour:
- Reset (rst=1 at an edge):
  - Clears vld_pipe, the FIFO pointers/count and err_overflow; sets credits=DEPTH.
  - issue_ready is forced 0 while rst=1.
  - In-flight adder results are discarded; no write occurs for them after reset.
- Alignment:
  - An issue accepted in cycle t loads vld_pipe[0]/tag_pipe[0] at the edge ending t, then shifts one stage per edge.
  - vld_pipe[LATENCY-1] is high during cycle t+LATENCY, which is the cycle add_result holds that result.
  - The FIFO write {add_result, tag, flags} occurs at the edge ending that cycle.
  - Non-issued cycles shift in valid=0; the pipe shifts every cycle unconditionally.
- Credits:
  - credits register, range 0..DEPTH, width clog2(DEPTH)+1.
  - Decrement on accepted issue; increment on pop (out_valid && out_ready); unchanged when both happen in the same cycle.
  - issue_ready = (credits != 0) && !rst. A pop frees a credit visible from the next cycle (conservative).
  - Invariant: credits + inflight + fifo_count == DEPTH.
- FIFO:
  - First-word-fall-through; out_valid = (count != 0).
  - Simultaneous write and read allowed at any count, including full.
  - out_data, out_tag and out_flags are forced to 0 when out_valid=0. The memory itself is not reset.
- Pointer wrap: DEPTH is a power of two, so pointers wrap naturally. Full/empty is decided by count, not by pointer compare.
- Classification of add_result at write, with exp=[30:23] and man=[22:0]:
  - is_nan = exp==8'hFF && man!=0
  - is_inf = exp==8'hFF && man==0
  - is_zero = exp==0 && man==0 (denormals are not zero)
  - is_neg = bit31. This applies to NaN and −0 too.
- Latency: issue in cycle t → out_valid earliest in cycle t+LATENCY+1.
- Throughput: with out_ready held at 1, one result per cycle is sustained, with issue_ready permanently 1.
- err_overflow sets when a write occurs while count==DEPTH and no pop happens in the same cycle. It clears only on rst.

Decomposition:
- fadd_pkg holds:
  - FADD_LATENCY=4
  - EXP_MAX=8'hFF
  - FLAG_NAN/INF/ZERO/NEG bit indices
  - function classify_fp32(word) → 4-bit flags
- Sub-module sync_fifo (params WIDTH, DEPTH), first-word-fall-through, with count output. It stores {data, tag, flags} = 36+TAG_W bits.
- The collector itself holds the shift register, the credit counter and the classify call.

Test Plan:
- Single op: issue tag=3 at t=2, bench drives add_result=0x41BF3E67 at t=6 → out_valid at t=7, out_data=0x41BF3E67, out_tag=3, out_flags=0000. Pop → out_valid=0.
- NaN propagation: add_result=0x7FC00001 in the aligned cycle → out_flags=1000. For 0xFF800000 → 0101. For 0x80000000 → 0011.
- Backpressure/credits: out_ready=0, issue every cycle → exactly 8 accepts (tags 0..7), then issue_ready=0. All 8 results enter the FIFO, count=8, err_overflow=0. Raise out_ready → tags pop in order 0..7, and issue_ready returns the cycle after the first pop.
- Bubbles: issues at cycles 0, 2, 3 → exactly three FIFO writes at cycles 4, 6, 7. add_result garbage in cycle 5 is not captured.
- Streaming: out_ready=1, 100 back-to-back issues → issue_ready never drops, 100 results out in order, credits=8 at end.
- Reset mid-flight: 3 issues in flight plus 2 in the FIFO, assert rst one cycle → out_valid=0, credits=8, and no further writes from the flushed ops.
